// File: rtl/sya_ctrl.sv
// rtl/sya_ctrl.sv - Output-stationary systolic array sequencer (feed, skew flush, row drain)
module sya_ctrl #(
  parameter int NUM_ROW    = 16,
  parameter int NUM_COL    = 16,
  parameter int K_WIDTH    = 12,
  parameter int TILE_WIDTH = 10,
  parameter int FLUSH_LEN  = NUM_ROW + NUM_COL - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [K_WIDTH-1:0]         cfg_k,
  input  logic [TILE_WIDTH-1:0]      cfg_ntile,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_vld,
  output logic                       in_rdy,
  output logic                       in_zero,
  output logic                       arr_en,
  output logic                       arr_acc_reset,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [$clog2(NUM_ROW)-1:0] out_row,
  output logic [TILE_WIDTH-1:0]      out_tile
);

  localparam int ROW_W   = $clog2(NUM_ROW);
  localparam int FLUSH_W = $clog2(FLUSH_LEN + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_ROW - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                 state_q;
  logic [K_WIDTH-1:0]     k_q;
  logic [K_WIDTH-1:0]     kcnt_q;
  logic [TILE_WIDTH-1:0]  ntile_q;
  logic [TILE_WIDTH-1:0]  tcnt_q;
  logic [FLUSH_W-1:0]     fcnt_q;
  logic [ROW_W-1:0]       rcnt_q;

  logic feeding;
  logic draining;
  logic last_beat;
  logic last_row;
  logic last_tile;

  // Phase decodes and end-of-count compares (equality only, so full-scale configs never wrap)
  always_comb begin
    feeding   = (state_q == S_FEED);
    draining  = (state_q == S_DRAIN);
    last_beat = (kcnt_q == k_q - 1'b1);
    last_row  = (rcnt_q == ROW_LAST);
    last_tile = (tcnt_q == ntile_q - 1'b1);
  end

  // Array-edge controls: only in_vld may reach these combinationally, so a bubble stalls the array
  always_comb begin
    in_rdy        = feeding;
    arr_en        = feeding ? in_vld : (state_q == S_FLUSH);
    arr_acc_reset = feeding & in_vld & (kcnt_q == '0);
  end

  // Status and drain outputs decoded purely from registered state/counters
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    in_zero  = (state_q == S_FLUSH);
    out_vld  = draining;
    out_row  = draining ? rcnt_q : '0;
    out_tile = draining ? tcnt_q : '0;
  end

  // Sequencer: per tile feed cfg_k beats, flush the skew with zero beats, drain rows one per handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      kcnt_q  <= '0;
      ntile_q <= '0;
      tcnt_q  <= '0;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_q     <= cfg_k;
            ntile_q <= cfg_ntile;
            kcnt_q  <= '0;
            tcnt_q  <= '0;
            fcnt_q  <= '0;
            rcnt_q  <= '0;
            state_q <= ((cfg_k == '0) || (cfg_ntile == '0)) ? S_DONE : S_FEED;
          end
        end
        S_FEED: begin
          if (in_vld) begin
            if (last_beat) begin
              kcnt_q  <= '0;
              state_q <= S_FLUSH;
            end else begin
              kcnt_q <= kcnt_q + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (fcnt_q == FLUSH_LAST) begin
            fcnt_q  <= '0;
            state_q <= S_DRAIN;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_rdy) begin
            if (last_row) begin
              rcnt_q  <= '0;
              tcnt_q  <= tcnt_q + 1'b1;
              state_q <= last_tile ? S_DONE : S_FEED;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sya_ctrl.md
Name: sya_ctrl

Overview:
- Sequencer for the output-stationary systolic array built from the weight-stationary-free MAC PEs (act flows right, wgt flows down, psum held in place).
- Per output tile it:
  - streams cfg_k reduction beats into the array edge, asserting the accumulate-reset flag on the first beat;
  - flushes the diagonal skew with zero beats while the array stays enabled;
  - freezes the array and hands results out one row per handshake.
- Sits between the act/wgt edge buffers and the psum writeback path. Driven by the layer scheduler through a start/done handshake.

Parameters:
- NUM_ROW, 16, array rows (drain granularity = one row).
- NUM_COL, 16, array columns.
- K_WIDTH, 12, width of reduction-length config.
- TILE_WIDTH, 10, width of tile-count config.
- FLUSH_LEN, NUM_ROW+NUM_COL-1, zero-beat cycles after the last real beat.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset. One clock; reset is asynchronous and active-low.
- cfg_k, in, K_WIDTH, beats per tile; sampled on accepted start.
- cfg_ntile, in, TILE_WIDTH, tiles per job; sampled on accepted start.
- start, in, 1, job request pulse/level.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle job completion pulse.
- in_vld, in, 1, edge buffers present a valid act/wgt beat.
- in_rdy, out, 1, controller consumes a beat this cycle.
- in_zero, out, 1, edge muxes drive zeros into the array.
- arr_en, out, 1, global in_en_left to every PE.
- arr_acc_reset, out, 1, in_acc_reset_left into column 0.
- out_vld, out, 1, psum row available.
- out_rdy, in, 1, writeback accepts the row.
- out_row, out, clog2(NUM_ROW), row index being drained.
- out_tile, out, TILE_WIDTH, index of the tile being drained.

Behaviour:
- Reset values:
  - state IDLE; all counters 0.
  - busy, done, in_rdy, in_zero, arr_en, arr_acc_reset and out_vld all 0.
  - out_row 0, out_tile 0.
- Reset mid-operation aborts the job immediately with no done pulse; array contents are don't-care.
- States: IDLE, FEED, FLUSH, DRAIN, DONE. busy = (state != IDLE).
- IDLE:
  - start=1 latches cfg_k/cfg_ntile and clears kcnt/tcnt.
  - Next state is FEED, or DONE if cfg_k==0 or cfg_ntile==0 (no array activity; done still pulses).
- FEED:
  - in_rdy=1, in_zero=0.
  - beat = in_vld & in_rdy; arr_en = in_vld, so the array stalls (holds) on a bubble.
  - arr_acc_reset = beat & (kcnt==0).
  - kcnt increments per beat. The beat with kcnt==cfg_k-1 moves to FLUSH and clears kcnt.
- FLUSH:
  - in_rdy=0, in_zero=1, arr_en=1, arr_acc_reset=0.
  - Lasts exactly FLUSH_LEN cycles (fcnt), never stalls. Then DRAIN.
- DRAIN:
  - arr_en=0, so the accumulators hold. out_vld=1; out_row=rcnt; out_tile=tcnt.
  - rcnt advances on out_vld & out_rdy; out_row is stable while out_rdy=0.
  - On the handshake with rcnt==NUM_ROW-1: rcnt←0, tcnt++.
  - Then DONE if tcnt+1==cfg_ntile, else FEED. The next tile's first beat resets the accumulators.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored while busy. start held high in IDLE after DONE launches a new job (re-sampling cfg).
- in_rdy, arr_en and arr_acc_reset are combinational from state, counters and in_vld. All other outputs are decoded from registered state/counters only (no in→out comb path except in_vld→arr_en/arr_acc_reset).
- Counters compare with equality; cfg_k = 2^K_WIDTH-1 and cfg_ntile = 2^TILE_WIDTH-1 must complete without wrap.

Test Plan:
(NUM_ROW=NUM_COL=4, FLUSH_LEN=7; start sampled on the edge ending cycle 0)
- Basic flow: cfg_k=3, cfg_ntile=1, in_vld=1, out_rdy=1 ->
  - FEED cycles 1-3, arr_acc_reset only in cycle 1;
  - FLUSH 4-10 (in_zero=1, arr_en=1);
  - DRAIN 11-14 with out_row 0,1,2,3;
  - done=1 in cycle 15; busy=0 in cycle 16.
- Input bubbles: cfg_k=3, in_vld=1,0,0,1,1 in cycles 1-5 ->
  - arr_en=1,0,0,1,1;
  - arr_acc_reset only in cycle 1;
  - FLUSH starts in cycle 6.
- Output backpressure: out_rdy low for cycles 11-13 then high -> out_row holds 0 through cycle 13, rows 1-3 in cycles 15-17, arr_en=0 throughout DRAIN.
- Multi-tile: cfg_k=2, cfg_ntile=3 ->
  - three FEED/FLUSH/DRAIN sequences, each with exactly one arr_acc_reset on its first beat;
  - out_tile 0,1,2;
  - one done pulse total.
- Degenerate config: cfg_k=0 or cfg_ntile=0 -> no arr_en/in_rdy activity, done=1 in cycle 1, busy back to 0 in cycle 2. A start pulse during busy is ignored (job length unchanged).
- Reset mid-job: rst_n low during FLUSH -> all outputs 0 asynchronously, no done pulse. A fresh start after release runs a full correct job.
